pma_settings_csr_responder: RTL and testbench
=============================================

# pma_settings_csr_responder

Avalon-MM responder holding shadow and active PMA analog settings (VOD, pre-emphasis tap, RX equalization) per transceiver channel. It is the target that the default-PMA-settings configuration master writes and reads over its active-low write_n/read_n bus. Shadow registers are written freely. A commit write copies all shadows to the active outputs, pulses an update strobe to the PMA, and stalls the bus for a fixed settle window.

## Interface
- NUM_CH, default 4: number of channels, 1..4.
- READ_LATENCY, default 2: cycles from read acceptance to readdatavalid, 1..4.
- COMMIT_CYCLES, default 16: waitrequest hold after a commit, >=1.

Ports:
- clock  in  1  single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- slave_wen  in  1  write_n, active low.
- slave_oen  in  1  read_n, active low.
- slave_be  in  4  byteenable.
- slave_address  in  32  byte address.
- slave_wdata  in  32  write data.
- slave_rdata  out  32  read data.
- readdatavalid_out  out  1  read data valid.
- waitrequest_out  out  1  stall.
- pma_vod  out  6*NUM_CH  active VOD per channel.
- pma_pretap  out  5*NUM_CH  active pre-emphasis tap per channel.
- pma_rxeq  out  4*NUM_CH  active RX equalization per channel.
- pma_update  out  1  one-cycle pulse when active values change.

## Operation
- Address map (byte):
  - 0x00 + 0x10*ch: VOD[5:0]
  - 0x04 + 0x10*ch: PRETAP[4:0]
  - 0x08 + 0x10*ch: RXEQ[3:0]
  - 0x0C + 0x10*ch: read-only active VOD/PRETAP/RXEQ packed at [5:0], [12:8], [19:16]
  - 0x100: COMMIT (write-only; reads return 0)
  - 0x104: ID/STATUS (read-only; [31:16]=16'h5D1C, [15:8]=commit_count, [0]=range_err)
  - Address bits [1:0] are ignored. Channels >= NUM_CH are unmapped.
- Writes: a register updates only when slave_be[0]=1. Register bits above the field width are ignored. Reads return the field zero-extended.
- Writes to read-only or unmapped addresses are accepted and have no effect.
- Reads of unmapped addresses return 0.
- Commit: an accepted COMMIT write with be[0]=1 and wdata[0]=1:
  - copies every shadow register to its active output;
  - increments commit_count (8-bit, wraps 0xFF->0x00);
  - enters BUSY.
  - A COMMIT write with wdata[0]=0 is a no-op.
- FSM:
  - IDLE: accepts accesses.
  - IDLE->BUSY on commit.
  - BUSY holds waitrequest_out=1 for COMMIT_CYCLES cycles (down-counter), then returns to IDLE.
- If slave_wen=0 and slave_oen=0 in the same cycle, the write wins and no readdatavalid is generated.
- Reset values:
  - shadow and active: VOD=30, PRETAP=0, RXEQ=2;
  - commit_count=0, range_err=0;
  - slave_rdata=0, readdatavalid_out=0, pma_update=0;
  - waitrequest_out=1 while reset_n=0.
- Reset asserted mid-BUSY or mid-read aborts without generating readdatavalid.

## Timing
- Acceptance: the cycle where (slave_wen=0 or slave_oen=0) and waitrequest_out=0.
- waitrequest_out drops to 0 on the first clock edge after reset_n rises. Outside BUSY it is combinationally 0.
- Write effect is visible in a register on the edge of acceptance.
- Read data comes from the registered values at acceptance. readdatavalid_out is high exactly READ_LATENCY cycles later, for 1 cycle.
- Reads are fully pipelined: one per cycle, in order.
- A read accepted the cycle before a commit returns pre-commit active values.
- Reads in flight when BUSY starts still complete on schedule.
- pma_update is high in the cycle after commit acceptance, when the active outputs first show the new values.
- Back-to-back commits: the second is stalled by BUSY. Minimum spacing is COMMIT_CYCLES+1 cycles.
- slave_rdata holds its last value when readdatavalid_out=0.

## Configuration
- PMA_CSR_RANGE_ERR_EN defined:
  - any accepted access to an unmapped or read-only-for-write address sets sticky range_err;
  - unmapped reads return 32'hBADADD00;
  - a write to 0x104 with wdata[0]=1 clears range_err.
- Undefined: range_err is tied 0, unmapped reads return 0, writes to 0x104 are ignored.

## Structure
- Package pma_csr_pkg holds:
  - register offsets, field widths and reset values;
  - ID constant 16'h5D1C and the BADADD00 constant;
  - the FSM state enum (IDLE, BUSY).
- Sub-module pma_csr_rd_pipe: READ_LATENCY-deep valid/data shift pipeline with asynchronous active-low reset.

## Test plan
- Reset release: waitrequest_out 1->0 after the first edge; reading 0x0C returns 0x0002001E; ID read returns 0x5D1C0000.
- Write 0x00=0x25 with be=0xF, then 0x04=0x3 with be=0x0, then commit. Required:
  - pma_vod[5:0]=0x25 and pma_pretap[4:0]=0;
  - pma_update is a single pulse;
  - waitrequest_out is high for exactly 16 cycles;
  - commit_count=1.
- Four back-to-back reads (0x00, 0x04, 0x08, 0x104): four consecutive readdatavalid pulses, in order, each 2 cycles after its acceptance.
- Read issued during BUSY is stalled until BUSY ends, then returns data 2 cycles after acceptance. A simultaneous wen=0/oen=0 access performs the write with no readdatavalid.
- With PMA_CSR_RANGE_ERR_EN and NUM_CH=2: read 0x20 returns 0xBADADD00 and sets range_err (0x104 bit0=1); writing 0x104=1 clears it.
- 256 commits: commit_count wraps to 0x00. reset_n pulsed low mid-BUSY: waitrequest_out=1 during reset, outputs return to reset values, no stray readdatavalid.

Source files
------------

// File: rtl/pma_csr_pkg.sv
// pma_csr_pkg: register map, field widths, reset values and FSM states for the PMA settings CSR block.
package pma_csr_pkg;

    localparam int VOD_W    = 6;
    localparam int PRETAP_W = 5;
    localparam int RXEQ_W   = 4;

    localparam logic [1:0] REG_VOD    = 2'd0;
    localparam logic [1:0] REG_PRETAP = 2'd1;
    localparam logic [1:0] REG_RXEQ   = 2'd2;
    localparam logic [1:0] REG_ACTIVE = 2'd3;

    localparam logic [31:0] ADDR_COMMIT = 32'h0000_0100;
    localparam logic [31:0] ADDR_ID     = 32'h0000_0104;

    localparam logic [VOD_W-1:0]    VOD_RST    = 6'd30;
    localparam logic [PRETAP_W-1:0] PRETAP_RST = 5'd0;
    localparam logic [RXEQ_W-1:0]   RXEQ_RST   = 4'd2;

    localparam logic [15:0] ID_CONST      = 16'h5D1C;
    localparam logic [31:0] BAD_ADDR_DATA = 32'hBADA_DD00;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic [31:0] unmapped_rdata(input logic err_en);
        return err_en ? BAD_ADDR_DATA : 32'h0;
    endfunction

endpackage

// File: rtl/pma_csr_rd_pipe.sv
// pma_csr_rd_pipe: LAT-deep read valid/data shift pipeline.
// Ports: clock, reset_n (async active-low), in_valid/in_data (accepted read),
//        out_valid/out_data (response LAT cycles later; out_data holds between responses).
module pma_csr_rd_pipe #(
    parameter int LAT = 2,
    parameter int W   = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic [LAT-1:0] vld;
    logic [W-1:0]   dat [LAT];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) dat[0] <= in_data;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_data  = dat[LAT-1];

endmodule

// File: rtl/pma_settings_csr_responder.sv
// pma_settings_csr_responder: Avalon-MM target with shadow/active PMA settings and a stalling commit.
// Ports: clock, reset_n (async active-low); slave_wen/slave_oen (active-low write/read),
//        slave_be, slave_address (byte), slave_wdata, slave_rdata, readdatavalid_out, waitrequest_out;
//        pma_vod/pma_pretap/pma_rxeq (active values, channel 0 in the LSBs), pma_update (commit pulse).
// Optional: define PMA_CSR_RANGE_ERR_EN for the sticky range_err flag and BADADD00 unmapped reads.
module pma_settings_csr_responder
    import pma_csr_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int READ_LATENCY  = 2,
    parameter int COMMIT_CYCLES = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         slave_wen,
    input  logic                         slave_oen,
    input  logic [3:0]                   slave_be,
    input  logic [31:0]                  slave_address,
    input  logic [31:0]                  slave_wdata,
    output logic [31:0]                  slave_rdata,
    output logic                         readdatavalid_out,
    output logic                         waitrequest_out,
    output logic [VOD_W*NUM_CH-1:0]      pma_vod,
    output logic [PRETAP_W*NUM_CH-1:0]   pma_pretap,
    output logic [RXEQ_W*NUM_CH-1:0]     pma_rxeq,
    output logic                         pma_update
);
    localparam int            CW       = $clog2(COMMIT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(COMMIT_CYCLES - 1);

`ifdef PMA_CSR_RANGE_ERR_EN
    localparam logic RERR_EN = 1'b1;
`else
    localparam logic RERR_EN = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  out_of_reset_q;
    logic [VOD_W-1:0]      sh_vod     [NUM_CH];
    logic [PRETAP_W-1:0]   sh_pretap  [NUM_CH];
    logic [RXEQ_W-1:0]     sh_rxeq    [NUM_CH];
    logic [VOD_W-1:0]      act_vod    [NUM_CH];
    logic [PRETAP_W-1:0]   act_pretap [NUM_CH];
    logic [RXEQ_W-1:0]     act_rxeq   [NUM_CH];
    logic [7:0]            commit_count;
    logic                  range_err;
    logic                  wr_acc, rd_acc, ch_ok, is_commit, is_id, commit;
    logic [3:0]            ch;
    logic [1:0]            rsel;
    logic [31:0]           rd_data;
    logic                  unused;

    // Held high until the first edge after reset release, then only while BUSY.
    assign waitrequest_out = !out_of_reset_q || state_q == BUSY;
    // A simultaneous write/read is treated as a write only.
    assign wr_acc    = !slave_wen && !waitrequest_out;
    assign rd_acc    = slave_wen && !slave_oen && !waitrequest_out;
    assign ch        = slave_address[7:4];
    assign rsel      = slave_address[3:2];
    assign ch_ok     = slave_address[31:8] == 24'd0 && ch < 4'(NUM_CH);
    assign is_commit = slave_address[31:2] == ADDR_COMMIT[31:2];
    assign is_id     = slave_address[31:2] == ADDR_ID[31:2];
    assign commit    = wr_acc && is_commit && slave_be[0] && slave_wdata[0];
    assign unused    = ^{slave_be[3:1], slave_wdata[31:VOD_W]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            out_of_reset_q <= 1'b0;
            pma_update     <= 1'b0;
            commit_count   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            out_of_reset_q <= 1'b1;
            pma_update     <= commit;
            commit_count   <= commit_count + 8'(commit);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (commit) begin
                state_d = BUSY;
                cnt_d   = CNT_INIT;
            end
        end else if (cnt_q == '0) begin
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sh_vod[c]     <= VOD_RST;
                sh_pretap[c]  <= PRETAP_RST;
                sh_rxeq[c]    <= RXEQ_RST;
                act_vod[c]    <= VOD_RST;
                act_pretap[c] <= PRETAP_RST;
                act_rxeq[c]   <= RXEQ_RST;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_acc && slave_be[0] && ch_ok && ch == 4'(c)) begin
                    if (rsel == REG_VOD)    sh_vod[c]    <= slave_wdata[VOD_W-1:0];
                    if (rsel == REG_PRETAP) sh_pretap[c] <= slave_wdata[PRETAP_W-1:0];
                    if (rsel == REG_RXEQ)   sh_rxeq[c]   <= slave_wdata[RXEQ_W-1:0];
                end
                if (commit) begin
                    act_vod[c]    <= sh_vod[c];
                    act_pretap[c] <= sh_pretap[c];
                    act_rxeq[c]   <= sh_rxeq[c];
                end
            end
        end
    end

    // Read data is taken from the register state in the acceptance cycle.
    always_comb begin
        rd_data = '0;
        if (ch_ok) begin
            for (int c = 0; c < NUM_CH; c++)
                if (ch == 4'(c))
                    rd_data = rsel == REG_ACTIVE ? {12'd0, act_rxeq[c], 3'd0, act_pretap[c], 2'd0, act_vod[c]} :
                              rsel == REG_VOD    ? 32'(sh_vod[c]) :
                              rsel == REG_PRETAP ? 32'(sh_pretap[c]) : 32'(sh_rxeq[c]);
        end else if (is_id) begin
            rd_data = {ID_CONST, commit_count, 7'd0, range_err};
        end else if (!is_commit) begin
            rd_data = unmapped_rdata(RERR_EN);
        end
    end

`ifdef PMA_CSR_RANGE_ERR_EN
    logic range_err_q, err_hit;
    // 0x104 is writable here (clear), so only the per-channel active readback counts as read-only.
    assign err_hit = ((wr_acc || rd_acc) && !(ch_ok || is_commit || is_id)) ||
                     (wr_acc && ch_ok && rsel == REG_ACTIVE);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) range_err_q <= 1'b0;
        else if (err_hit) range_err_q <= 1'b1;
        else if (wr_acc && is_id && slave_be[0] && slave_wdata[0]) range_err_q <= 1'b0;
    end
    assign range_err = range_err_q;
`else
    assign range_err = 1'b0;
`endif

    pma_csr_rd_pipe #(.LAT(READ_LATENCY), .W(32)) u_rd_pipe (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (rd_acc),
        .in_data  (rd_data),
        .out_valid(readdatavalid_out),
        .out_data (slave_rdata)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign pma_vod[g*VOD_W +: VOD_W]          = act_vod[g];
        assign pma_pretap[g*PRETAP_W +: PRETAP_W] = act_pretap[g];
        assign pma_rxeq[g*RXEQ_W +: RXEQ_W]       = act_rxeq[g];
    end

endmodule

// File: tb/tb_pma_settings_csr_responder.sv
// tb_pma_settings_csr_responder: scoreboard bench with a register-map reference model for the PMA CSR responder.
module tb_pma_settings_csr_responder;
    localparam int NUM_CH = 4;
    localparam int RL     = 2;
    localparam int CC     = 16;
`ifdef PMA_CSR_RANGE_ERR_EN
    localparam bit RERR = 1'b1;
`else
    localparam bit RERR = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 slave_wen = 1'b1;
    logic                 slave_oen = 1'b1;
    logic [3:0]           slave_be = 4'h0;
    logic [31:0]          slave_address = 32'h0;
    logic [31:0]          slave_wdata = 32'h0;
    logic [31:0]          slave_rdata;
    logic                 readdatavalid_out;
    logic                 waitrequest_out;
    logic [6*NUM_CH-1:0]  pma_vod;
    logic [5*NUM_CH-1:0]  pma_pretap;
    logic [4*NUM_CH-1:0]  pma_rxeq;
    logic                 pma_update;

    always #5 clock = ~clock;

    pma_settings_csr_responder #(.NUM_CH(NUM_CH), .READ_LATENCY(RL), .COMMIT_CYCLES(CC)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .slave_wen        (slave_wen),
        .slave_oen        (slave_oen),
        .slave_be         (slave_be),
        .slave_address    (slave_address),
        .slave_wdata      (slave_wdata),
        .slave_rdata      (slave_rdata),
        .readdatavalid_out(readdatavalid_out),
        .waitrequest_out  (waitrequest_out),
        .pma_vod          (pma_vod),
        .pma_pretap       (pma_pretap),
        .pma_rxeq         (pma_rxeq),
        .pma_update       (pma_update)
    );

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   lc = -1000;
    int   rel_cyc = -1;
    int   sh_v[NUM_CH], sh_p[NUM_CH], sh_e[NUM_CH];
    int   ac_v[NUM_CH], ac_p[NUM_CH], ac_e[NUM_CH];
    int   m_cnt;
    bit   m_err;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            sh_v[c] = 30; sh_p[c] = 0; sh_e[c] = 2;
            ac_v[c] = 30; ac_p[c] = 0; ac_e[c] = 2;
        end
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] a;
        int ch, r;
        a = addr & 32'hFFFF_FFFC;
        if (a < 32'(16 * NUM_CH)) begin
            ch = int'(a / 16);
            r  = int'((a % 16) / 4);
            if (r == 0) return 32'(sh_v[ch]);
            if (r == 1) return 32'(sh_p[ch]);
            if (r == 2) return 32'(sh_e[ch]);
            return 32'(ac_e[ch] * 65536 + ac_p[ch] * 256 + ac_v[ch]);
        end
        if (a == 32'h100) return 32'h0;
        if (a == 32'h104) return 32'h5D1C_0000 + 32'(m_cnt * 256) + 32'(m_err);
        return RERR ? 32'hBADA_DD00 : 32'h0;
    endfunction

    task automatic model_apply(input logic wen, input logic oen, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] be);
        logic [31:0] a;
        bit in_ch, unmapped;
        int ch, r;
        a        = addr & 32'hFFFF_FFFC;
        in_ch    = a < 32'(16 * NUM_CH);
        unmapped = !in_ch && a != 32'h100 && a != 32'h104;
        ch       = int'(a / 16);
        r        = int'((a % 16) / 4);
        if (!wen) begin
            if (in_ch && be[0]) begin
                if (r == 0) sh_v[ch] = int'(data % 64);
                if (r == 1) sh_p[ch] = int'(data % 32);
                if (r == 2) sh_e[ch] = int'(data % 16);
            end
            if (RERR && (unmapped || (in_ch && r == 3))) m_err = 1'b1;
            if (a == 32'h104 && RERR && be[0] && data[0]) m_err = 1'b0;
            if (a == 32'h100 && be[0] && data[0]) begin
                ac_v = sh_v; ac_p = sh_p; ac_e = sh_e;
                m_cnt = (m_cnt + 1) % 256;
                lc = cyc;
            end
        end else if (!oen) begin
            q.push_back('{model_read(addr), cyc});
            if (RERR && unmapped) m_err = 1'b1;
        end
    endtask

    // Called just after a posedge; returns just after the posedge that follows acceptance.
    task automatic access(input logic wen, input logic oen, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
        int n;
        slave_wen = wen; slave_oen = oen; slave_address = addr; slave_wdata = data; slave_be = be;
        n = 0;
        forever begin
            @(negedge clock);
            if (!waitrequest_out) break;
            n++;
            if (n > 100) break;
        end
        if (n > 100) begin
            errors++; checks++;
            $display("FAIL wait_timeout: waitrequest still %b after %0d cycles, required 0", waitrequest_out, n);
        end else begin
            model_apply(wen, oen, addr, data, be);
        end
        @(posedge clock); #1;
        slave_wen = 1'b1; slave_oen = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic check_act();
        @(negedge clock);
        for (int c = 0; c < NUM_CH; c++) begin
            chk("pma_vod", 32'(pma_vod[c*6 +: 6]), 32'(ac_v[c]));
            chk("pma_pretap", 32'(pma_pretap[c*5 +: 5]), 32'(ac_p[c]));
            chk("pma_rxeq", 32'(pma_rxeq[c*4 +: 4]), 32'(ac_e[c]));
        end
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        model_reset();
        lc = -1000;
        idle(3);
        reset_n = 1'b1;
        rel_cyc = cyc;
        @(negedge clock);
        chk("rdata_after_reset", slave_rdata, 32'h0);
        @(posedge clock); #1;
        check_act();
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            chk("wait_in_reset", 32'(waitrequest_out), 32'h1);
            chk("rdv_in_reset", 32'(readdatavalid_out), 32'h0);
        end else begin
            chk("waitrequest", 32'(waitrequest_out), 32'(cyc == rel_cyc || (cyc > lc && cyc <= lc + CC)));
            chk("pma_update", 32'(pma_update), 32'(cyc == lc + 1));
            if (readdatavalid_out) begin
                if (q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_rdv: readdatavalid_out=1 with rdata %h, required no response", slave_rdata);
                end else begin
                    e = q.pop_front();
                    chk("rdata", slave_rdata, e.d);
                    chk("rd_latency", 32'(cyc - e.c), 32'(RL));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic        wen, oen;
        logic [31:0] ad, dt;
        logic [3:0]  b;
        int          k;
        reset_n = 1'b0;
        @(posedge clock); #1;
        do_reset();
        access(1'b1, 1'b0, 32'h0C, 32'h0, 4'hF);
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
        access(1'b0, 1'b1, 32'h00, 32'h25, 4'hF);
        access(1'b0, 1'b1, 32'h04, 32'h3, 4'h0);
        access(1'b0, 1'b1, 32'h100, 32'h1, 4'hF);
        idle(20);
        check_act();
        access(1'b1, 1'b0, 32'h00, 32'h0, 4'hF);
        access(1'b1, 1'b0, 32'h04, 32'h0, 4'hF);
        access(1'b1, 1'b0, 32'h08, 32'h0, 4'hF);
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
        idle(4);
        access(1'b0, 1'b1, 32'h14, 32'h11, 4'h1);
        access(1'b1, 1'b0, 32'h1C, 32'h0, 4'hF);
        access(1'b0, 1'b1, 32'h100, 32'h1, 4'hF);
        access(1'b1, 1'b0, 32'h1F, 32'h0, 4'hF);
        access(1'b0, 1'b0, 32'h08, 32'h7, 4'hF);
        idle(3);
        access(1'b1, 1'b0, 32'h08, 32'h0, 4'hF);
        access(1'b0, 1'b1, 32'h100, 32'h0, 4'hF);
        idle(3);
        access(1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
        access(1'b0, 1'b1, 32'h0C, 32'h1, 4'hF);
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
        access(1'b0, 1'b1, 32'h104, 32'h1, 4'hF);
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
        access(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        access(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        for (int i = 0; i < 400; i++) begin
            k  = int'($urandom_range(0, 9));
            ad = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 16 * NUM_CH - 1));
            dt = $urandom;
            b  = 4'($urandom_range(0, 15));
            wen = !(k < 4 || k == 8 || k == 9);
            oen = !(k >= 4 && k <= 8);
            if (k == 9) ad = 32'h100 | 32'($urandom_range(0, 3));
            access(wen, oen, ad, dt, b);
        end
        idle(20);
        check_act();
        repeat (256) access(1'b0, 1'b1, 32'h100, 32'h1, 4'hF);
        idle(20);
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
        check_act();
        access(1'b1, 1'b0, 32'h00, 32'h0, 4'hF);
        do_reset();
        access(1'b0, 1'b1, 32'h00, 32'h5, 4'hF);
        access(1'b0, 1'b1, 32'h100, 32'h1, 4'hF);
        idle(4);
        do_reset();
        access(1'b1, 1'b0, 32'h0C, 32'h0, 4'hF);
        access(1'b1, 1'b0, 32'h00, 32'h0, 4'hF);
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
        idle(10);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
